// File: rtl/fifo_stream_reader.sv
// Drains the read port of an asynchronous FIFO into a valid/ready stream.
// Reads are credit-limited so every returning word has a guaranteed buffer slot.
module fifo_stream_reader #(
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1,
   parameter int BUFFER_DEPTH = 4,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               fifo_empty,
   input  logic [DATA_WIDTH-1:0]              fifo_read_data,
   input  logic                               fifo_read_data_valid,
   output logic                               fifo_read_enable,
   input  logic                               flush,
   input  logic                               stream_ready,
   output logic                               stream_valid,
   output logic [DATA_WIDTH-1:0]              stream_data,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0]  buffer_level,
   output logic [COUNT_WIDTH-1:0]             words_transferred,
   output logic                               protocol_error
);

   localparam int LW = $clog2(BUFFER_DEPTH + 1);
   localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST     = PW'(BUFFER_DEPTH - 1);
   localparam logic [LW:0]   CREDIT_LIMIT = (LW + 1)'(BUFFER_DEPTH);

   generate
      if (BUFFER_DEPTH < READ_LATENCY + 2) begin : g_depth_check
         $error("fifo_stream_reader: BUFFER_DEPTH must be at least READ_LATENCY+2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] buffer_mem [BUFFER_DEPTH];
   logic [PW-1:0]         head_ptr;
   logic [PW-1:0]         tail_ptr;
   logic [LW-1:0]         outstanding;
   logic [LW-1:0]         discard_count;
   logic [LW:0]           credit_used;
   logic [LW:0]           pending_total;
   logic [LW:0]           flush_discard;
   logic                  word_accept;
   logic                  word_drop;
   logic                  word_error;
   logic                  beat;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
   endfunction

   assign credit_used      = {1'b0, buffer_level} + {1'b0, outstanding};
   assign fifo_read_enable = !reset && !fifo_empty && !flush &&
                             (discard_count == '0) && (credit_used < CREDIT_LIMIT);

   assign word_drop   = fifo_read_data_valid && (discard_count != '0);
   assign word_error  = fifo_read_data_valid && (discard_count == '0) && (outstanding == '0);
   assign word_accept = fifo_read_data_valid && (discard_count == '0) && (outstanding != '0);

   assign stream_valid = (buffer_level != '0) && !flush;
   assign stream_data  = (buffer_level != '0) ? buffer_mem[head_ptr] : '0;
   assign beat         = stream_valid && stream_ready;

   // A word returning during the flush cycle is itself one of the in-flight words.
   assign pending_total = {1'b0, discard_count} + {1'b0, outstanding};
   assign flush_discard = pending_total -
                          {{LW{1'b0}}, (fifo_read_data_valid && (pending_total != '0))};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buffer_level      <= '0;
         outstanding       <= '0;
         discard_count     <= '0;
         head_ptr          <= '0;
         tail_ptr          <= '0;
         words_transferred <= '0;
         protocol_error    <= 1'b0;
      end else if (flush) begin
         buffer_level  <= '0;
         outstanding   <= '0;
         head_ptr      <= '0;
         tail_ptr      <= '0;
         discard_count <= LW'(flush_discard);
         if (fifo_read_data_valid && (pending_total == '0)) begin
            protocol_error <= 1'b1;
         end
      end else begin
         outstanding  <= outstanding + LW'(fifo_read_enable) - LW'(word_accept);
         buffer_level <= buffer_level + LW'(word_accept) - LW'(beat);
         if (word_drop) begin
            discard_count <= discard_count - LW'(1);
         end
         if (word_error) begin
            protocol_error <= 1'b1;
         end
         if (word_accept) begin
            tail_ptr <= ptr_inc(tail_ptr);
         end
         if (beat) begin
            head_ptr          <= ptr_inc(head_ptr);
            words_transferred <= words_transferred + COUNT_WIDTH'(1);
         end
      end
   end

   // Storage is data only; occupancy is tracked by buffer_level, so no reset.
   always_ff @(posedge clock) begin
      if (word_accept) begin
         buffer_mem[tail_ptr] <= fifo_read_data;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small FIFO model with selectable read
// latency feeds two instances (32-bit and 4-bit transfer counters).
module tb_fifo_stream_reader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        force_vld = 1'b0;
   logic        a_flush = 1'b0, b_flush = 1'b0;
   logic        a_ready = 1'b0, b_ready = 1'b0;
   logic        track = 1'b0, track_clr = 1'b0;
   int          lat = 1;

   logic [15:0] fmem [0:255];
   int          rp, wp;
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [15:0] p1_d = '0, p2_d = '0;
   logic        f_empty, f_vld;
   logic [15:0] f_data;

   logic        a_empty, a_vld, a_rd, a_sv, a_perr;
   logic [15:0] a_sd;
   logic [2:0]  a_level;
   logic [31:0] a_wt;
   logic        b_empty, b_vld, b_rd, b_sv, b_perr;
   logic [15:0] b_sd;
   logic [2:0]  b_level;
   logic [3:0]  b_wt;
   logic        rd_sel;

   int          rd_cnt, vld_cnt, max_out, max_lvl;
   int          vectors, miscompares;
   int          rd0;

   always #5 clock = ~clock;

   fifo_stream_reader #(.DATA_WIDTH(16), .READ_LATENCY(2), .BUFFER_DEPTH(4), .COUNT_WIDTH(32)) dut_a (
      .clock(clock), .reset(reset), .fifo_empty(a_empty), .fifo_read_data(f_data),
      .fifo_read_data_valid(a_vld), .fifo_read_enable(a_rd), .flush(a_flush),
      .stream_ready(a_ready), .stream_valid(a_sv), .stream_data(a_sd),
      .buffer_level(a_level), .words_transferred(a_wt), .protocol_error(a_perr));

   fifo_stream_reader #(.DATA_WIDTH(16), .READ_LATENCY(1), .BUFFER_DEPTH(4), .COUNT_WIDTH(4)) dut_b (
      .clock(clock), .reset(reset), .fifo_empty(b_empty), .fifo_read_data(f_data),
      .fifo_read_data_valid(b_vld), .fifo_read_enable(b_rd), .flush(b_flush),
      .stream_ready(b_ready), .stream_valid(b_sv), .stream_data(b_sd),
      .buffer_level(b_level), .words_transferred(b_wt), .protocol_error(b_perr));

   // FIFO model: reset together with the readers, latency 1 or 2.
   assign f_empty = (rp == wp);
   assign f_vld   = (lat == 1) ? p1_v : p2_v;
   assign f_data  = (lat == 1) ? p1_d : p2_d;
   assign a_empty = sel ? 1'b1 : f_empty;
   assign a_vld   = sel ? 1'b0 : f_vld;
   assign b_empty = sel ? f_empty : 1'b1;
   assign b_vld   = (sel & f_vld) | force_vld;
   assign rd_sel  = sel ? b_rd : a_rd;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         p1_v <= 1'b0;
         p2_v <= 1'b0;
         rp   <= wp;
      end else begin
         p1_v <= rd_sel;
         p2_v <= p1_v;
         p2_d <= p1_d;
         if (rd_sel) begin
            p1_d <= fmem[rp];
            rp   <= rp + 1;
         end
      end
   end

   always @(posedge clock) begin
      if (!reset) begin
         if (rd_sel) rd_cnt <= rd_cnt + 1;
         if (!sel && f_vld) vld_cnt <= vld_cnt + 1;
      end
   end

   always @(negedge clock) begin
      if (track_clr) begin
         max_out <= 0;
         max_lvl <= 0;
      end else if (track) begin
         if (rd_cnt - vld_cnt > max_out) max_out <= rd_cnt - vld_cnt;
         if (int'(a_level) > max_lvl) max_lvl <= int'(a_level);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      fmem[wp] = w;
      wp = wp + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_sv(input logic on_b, input string tag);
      int n = 0;
      while (((on_b ? b_sv : a_sv) !== 1'b1) && (n < 20)) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, (on_b ? b_sv : a_sv)}, 32'd1);
   endtask

   task automatic recv(input logic on_b, input logic [15:0] exp, input string tag);
      wait_sv(on_b, {tag, "_valid"});
      chk(tag, {16'd0, (on_b ? b_sd : a_sd)}, {16'd0, exp});
      tick();
   endtask

   initial begin
      // Reset state, read request gated while reset is held
      tick();
      tick();
      push(16'hFFFF);
      #1;
      chk("reset_level", {29'd0, a_level}, 32'd0);
      chk("reset_valid", {31'd0, a_sv}, 32'd0);
      chk("reset_data", {16'd0, a_sd}, 32'd0);
      chk("reset_rd_en", {31'd0, a_rd}, 32'd0);
      chk("reset_count", a_wt, 32'd0);
      chk("reset_perr", {31'd0, a_perr}, 32'd0);
      tick();
      reset = 1'b0;

      // Streaming 16 words at full rate
      a_ready = 1'b1;
      for (int i = 1; i <= 16; i++) push(16'(i));
      #1;
      chk("stream_rd_en_start", {31'd0, a_rd}, 32'd1);
      wait_sv(1'b0, "stream_first_valid");
      for (int i = 1; i <= 16; i++) begin
         chk("stream_valid", {31'd0, a_sv}, 32'd1);
         chk("stream_data", {16'd0, a_sd}, 32'(i));
         tick();
      end
      chk("stream_count", a_wt, 32'd16);
      chk("stream_rd_en_empty", {31'd0, a_rd}, 32'd0);
      chk("stream_drained", {31'd0, a_sv}, 32'd0);

      // Back-pressure with 10 words queued
      a_ready = 1'b0;
      rd0 = rd_cnt;
      for (int i = 1; i <= 10; i++) push(16'h0100 + 16'(i));
      repeat (8) tick();
      chk("bp_reads_issued", 32'(rd_cnt - rd0), 32'd4);
      chk("bp_level", {29'd0, a_level}, 32'd4);
      chk("bp_valid", {31'd0, a_sv}, 32'd1);
      chk("bp_data", {16'd0, a_sd}, 32'h0101);
      chk("bp_rd_en", {31'd0, a_rd}, 32'd0);
      repeat (3) tick();
      chk("bp_data_held", {16'd0, a_sd}, 32'h0101);
      a_ready = 1'b1;
      for (int i = 1; i <= 10; i++) recv(1'b0, 16'h0100 + 16'(i), "bp_word");
      chk("bp_count", a_wt, 32'd26);
      chk("bp_level_empty", {29'd0, a_level}, 32'd0);

      // Latency-2 FIFO at full rate
      lat = 2;
      track_clr = 1'b1;
      tick();
      track_clr = 1'b0;
      track = 1'b1;
      for (int i = 1; i <= 8; i++) push(16'h0300 + 16'(i));
      wait_sv(1'b0, "lat2_first_valid");
      for (int i = 1; i <= 8; i++) begin
         chk("lat2_valid", {31'd0, a_sv}, 32'd1);
         chk("lat2_data", {16'd0, a_sd}, {16'd0, 16'h0300 + 16'(i)});
         tick();
      end
      track = 1'b0;
      tick();
      chk("lat2_max_outstanding", {31'd0, (max_out <= 2)}, 32'd1);
      chk("lat2_max_level", {31'd0, (max_lvl <= 2)}, 32'd1);
      chk("lat2_count", a_wt, 32'd34);

      // Flush with two reads in flight
      for (int i = 1; i <= 6; i++) push(16'h0400 + 16'(i));
      tick();
      tick();
      a_flush = 1'b1;
      #1;
      chk("flush_rd_en", {31'd0, a_rd}, 32'd0);
      chk("flush_valid", {31'd0, a_sv}, 32'd0);
      tick();
      a_flush = 1'b0;
      #1;
      chk("flush_level", {29'd0, a_level}, 32'd0);
      chk("flush_discard_hold", {31'd0, a_rd}, 32'd0);
      for (int i = 3; i <= 6; i++) recv(1'b0, 16'h0400 + 16'(i), "flush_word");
      chk("flush_count", a_wt, 32'd38);
      chk("flush_no_perr", {31'd0, a_perr}, 32'd0);

      // Protocol error and 4-bit counter wrap
      lat = 1;
      sel = 1'b1;
      b_ready = 1'b1;
      force_vld = 1'b1;
      tick();
      force_vld = 1'b0;
      #1;
      chk("perr_set", {31'd0, b_perr}, 32'd1);
      chk("perr_word_dropped", {29'd0, b_level}, 32'd0);
      for (int i = 1; i <= 17; i++) push(16'h0600 + 16'(i));
      for (int i = 1; i <= 17; i++) recv(1'b1, 16'h0600 + 16'(i), "wrap_word");
      chk("wrap_count", {28'd0, b_wt}, 32'd1);
      chk("perr_sticky", {31'd0, b_perr}, 32'd1);

      // Asynchronous reset mid-stream
      sel = 1'b0;
      b_ready = 1'b0;
      a_ready = 1'b0;
      for (int i = 1; i <= 3; i++) push(16'h0700 + 16'(i));
      repeat (6) tick();
      chk("mid_level", {29'd0, a_level}, 32'd3);
      chk("mid_data", {16'd0, a_sd}, 32'h0701);
      push(16'h0704);
      push(16'h0705);
      #1;
      chk("mid_rd_en", {31'd0, a_rd}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_level", {29'd0, a_level}, 32'd0);
      chk("async_valid", {31'd0, a_sv}, 32'd0);
      chk("async_data", {16'd0, a_sd}, 32'd0);
      chk("async_rd_en", {31'd0, a_rd}, 32'd0);
      chk("async_count", a_wt, 32'd0);
      chk("async_perr_clear", {31'd0, b_perr}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      a_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(16'h0800 + 16'(i));
      for (int i = 1; i <= 4; i++) recv(1'b0, 16'h0800 + 16'(i), "post_reset_word");
      chk("post_reset_count", a_wt, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
